// File: rtl/call_scheduler.sv
// Call scheduler: latches per-floor call buttons into a pending register and picks
// the next target floor using SCAN (keep direction while calls remain ahead).
module call_scheduler #(
    parameter int unsigned N_FLOORS = 8,
    parameter int unsigned FLOOR_W  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] btn,
    input  logic [FLOOR_W-1:0]  etaj_curent,
    input  logic                door_open,
    output logic [FLOOR_W-1:0]  etaj_cerut,
    output logic                cerere_valida,
    output logic                directie,
    output logic [N_FLOORS-1:0] pending
);

    typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;

    state_e              state_q, state_d;
    logic [N_FLOORS-1:0] btn_q;
    logic [N_FLOORS-1:0] press;
    logic [N_FLOORS-1:0] here;
    logic [N_FLOORS-1:0] pending_d;
    logic                above, below;
    logic [FLOOR_W-1:0]  up_tgt, dn_tgt, tgt_d;

    assign press = btn & ~btn_q;

    // One-hot of the current floor; an out-of-range floor matches nothing.
    always_comb begin
        here = '0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            if (etaj_curent == FLOOR_W'(i)) here[i] = 1'b1;
        end
    end

    // Clearing beats setting: a press at the open-door floor is already served.
    assign pending_d = (pending | press) & ~(here & {N_FLOORS{door_open}});

    // Lowest pending floor above and highest pending floor below the car.
    always_comb begin
        above  = 1'b0;
        below  = 1'b0;
        up_tgt = '0;
        dn_tgt = '0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) > etaj_curent) && !above) begin
                above  = 1'b1;
                up_tgt = FLOOR_W'(i);
            end
            if (pending[i] && (FLOOR_W'(i) < etaj_curent)) begin
                below  = 1'b1;
                dn_tgt = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (above)      state_d = StUp;
                else if (below) state_d = StDown;
            end
            StUp: begin
                if (!above) state_d = below ? StDown : StIdle;
            end
            StDown: begin
                if (!below) state_d = above ? StUp : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tgt_d = etaj_cerut;
        case (state_d)
            StUp:    tgt_d = up_tgt;
            StDown:  tgt_d = dn_tgt;
            default: if (|(pending & here)) tgt_d = etaj_curent;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            btn_q         <= '0;
            pending       <= '0;
            etaj_cerut    <= '0;
            cerere_valida <= 1'b0;
            directie      <= 1'b0;
        end else begin
            state_q       <= state_d;
            btn_q         <= btn;
            pending       <= pending_d;
            etaj_cerut    <= tgt_d;
            cerere_valida <= |pending_d;
            directie      <= (state_d == StUp);
        end
    end

endmodule

// File: tb/tb_call_scheduler.sv
// Bench for call_scheduler: cycle-by-cycle comparison against a floor-list model,
// plus directed scenarios with hand-derived expectations.
module tb_call_scheduler;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] btn   = '0;
    logic [2:0] etaj  = '0;
    logic       door  = 1'b0;

    logic [2:0] etaj_cerut;
    logic       cerere_valida;
    logic       directie;
    logic [7:0] pending;

    call_scheduler #(
        .N_FLOORS(8),
        .FLOOR_W (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn),
        .etaj_curent  (etaj),
        .door_open    (door),
        .etaj_cerut   (etaj_cerut),
        .cerere_valida(cerere_valida),
        .directie     (directie),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: pending floors as a bit list, direction as 0=idle 1=up 2=down.
    logic [7:0] m_pending = '0;
    logic [7:0] m_btn_q   = '0;
    int         m_mode    = 0;
    logic [2:0] m_tgt     = '0;
    logic       m_cv      = 1'b0;
    logic       m_dir     = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pending = '0;
            m_btn_q   = '0;
            m_mode    = 0;
            m_tgt     = '0;
            m_cv      = 1'b0;
            m_dir     = 1'b0;
        end else begin
            automatic int         cur   = int'(etaj);
            automatic logic [7:0] press = btn & ~m_btn_q;
            automatic int         up    = -1;
            automatic int         dn    = -1;
            automatic int         nmode = m_mode;
            automatic logic [7:0] np    = m_pending;
            for (int f = 0; f < 8; f++) begin
                if (m_pending[f] && f > cur && up < 0) up = f;
                if (m_pending[f] && f < cur) dn = f;
            end
            if (m_mode == 1)      nmode = (up >= 0) ? 1 : (dn >= 0) ? 2 : 0;
            else if (m_mode == 2) nmode = (dn >= 0) ? 2 : (up >= 0) ? 1 : 0;
            else                  nmode = (up >= 0) ? 1 : (dn >= 0) ? 2 : 0;
            if (nmode == 1)      m_tgt = 3'(up);
            else if (nmode == 2) m_tgt = 3'(dn);
            else if (m_pending[cur]) m_tgt = 3'(cur);
            for (int f = 0; f < 8; f++) begin
                if (press[f]) np[f] = 1'b1;
                if (door && cur == f) np[f] = 1'b0;
            end
            m_pending = np;
            m_mode    = nmode;
            m_cv      = |np;
            m_dir     = (nmode == 1);
            m_btn_q   = btn;
        end
    end

    always @(posedge clk) begin
        #2;
        chk("cmp_pending", pending, m_pending);
        chk("cmp_etaj_cerut", etaj_cerut, m_tgt);
        chk("cmp_cerere_valida", cerere_valida, m_cv);
        chk("cmp_directie", directie, m_dir);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int scan_exp[8] = '{4, 5, 6, 7, 3, 2, 1, 0};

    initial begin
        cyc(2);
        chk("rst_pending", pending, 8'h00);
        chk("rst_cerut", etaj_cerut, 0);
        chk("rst_cv", cerere_valida, 0);
        chk("rst_dir", directie, 0);
        reset = 1'b1;
        cyc(1);

        // Single call from floor 0 to floor 5.
        btn = 8'h20;
        cyc(1);
        btn = 8'h00;
        chk("single_pending", pending, 8'h20);
        chk("single_cerut_early", etaj_cerut, 0);
        cyc(1);
        chk("single_cerut", etaj_cerut, 5);
        chk("single_dir", directie, 1);
        chk("single_cv", cerere_valida, 1);

        // SCAN ordering with the car at floor 2 heading up.
        etaj = 3'd2;
        btn  = 8'h02;
        cyc(1);
        btn = 8'h00;
        cyc(1);
        chk("scan_setup_pending", pending, 8'h22);
        chk("scan_setup_cerut", etaj_cerut, 5);
        btn = 8'h08;
        cyc(1);
        btn = 8'h00;
        cyc(1);
        chk("scan_cerut_3", etaj_cerut, 3);
        chk("scan_dir_up", directie, 1);
        etaj = 3'd3;
        door = 1'b1;
        cyc(1);
        door = 1'b0;
        chk("scan_clear3_pending", pending, 8'h22);
        chk("scan_cerut_5", etaj_cerut, 5);
        etaj = 3'd5;
        door = 1'b1;
        cyc(1);
        door = 1'b0;
        chk("scan_cerut_1", etaj_cerut, 1);
        chk("scan_dir_down", directie, 0);
        chk("scan_pending_1", pending, 8'h02);
        etaj = 3'd1;
        door = 1'b1;
        cyc(1);
        door = 1'b0;
        chk("scan_empty_pending", pending, 8'h00);
        chk("scan_empty_cv", cerere_valida, 0);
        chk("scan_hold_cerut", etaj_cerut, 1);
        cyc(1);
        chk("scan_hold_cerut2", etaj_cerut, 1);
        chk("scan_idle_dir", directie, 0);

        // Held button registers once; clear wins over a same-cycle press.
        btn = 8'h10;
        cyc(1);
        chk("held_set", pending, 8'h10);
        cyc(2);
        etaj = 3'd4;
        door = 1'b1;
        cyc(1);
        door = 1'b0;
        chk("held_cleared", pending, 8'h00);
        cyc(6);
        chk("held_no_retrigger", pending, 8'h00);
        btn = 8'h00;
        cyc(1);
        door = 1'b1;
        btn  = 8'h11;
        cyc(1);
        door = 1'b0;
        btn  = 8'h00;
        chk("clear_wins", pending, 8'h01);
        cyc(1);
        etaj = 3'd0;
        door = 1'b1;
        cyc(1);
        door = 1'b0;
        chk("floor0_cleared", pending, 8'h00);

        // Call at the current floor while idle.
        etaj = 3'd6;
        btn  = 8'h40;
        cyc(1);
        btn = 8'h00;
        chk("here_cv", cerere_valida, 1);
        cyc(1);
        chk("here_cerut", etaj_cerut, 6);
        chk("here_dir", directie, 0);
        cyc(3);
        chk("here_cv_hold", cerere_valida, 1);
        chk("here_cerut_hold", etaj_cerut, 6);
        door = 1'b1;
        cyc(1);
        door = 1'b0;
        chk("here_cleared_cv", cerere_valida, 0);

        // Reversal at the top floor.
        btn = 8'h81;
        cyc(1);
        btn = 8'h00;
        cyc(1);
        chk("rev_cerut_7", etaj_cerut, 7);
        chk("rev_dir_up", directie, 1);
        etaj = 3'd7;
        door = 1'b1;
        cyc(1);
        door = 1'b0;
        chk("rev_cerut_0", etaj_cerut, 0);
        chk("rev_dir_down", directie, 0);
        chk("rev_pending", pending, 8'h01);
        etaj = 3'd0;
        door = 1'b1;
        cyc(1);
        door = 1'b0;

        // All buttons at once, served in SCAN order from floor 3.
        etaj = 3'd3;
        btn  = 8'hFF;
        cyc(1);
        btn = 8'h00;
        chk("all_pending", pending, 8'hFF);
        cyc(1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("all_order_%0d", k), etaj_cerut, scan_exp[k]);
            etaj = 3'(scan_exp[k]);
            door = 1'b1;
            cyc(1);
            door = 1'b0;
        end
        chk("all_done_cv", cerere_valida, 0);

        // Reset mid-operation, with a button held through reset release.
        btn = 8'h2A;
        cyc(1);
        btn = 8'h00;
        cyc(1);
        chk("mid_pending", pending, 8'h2A);
        chk("mid_cerut", etaj_cerut, 1);
        chk("mid_dir", directie, 1);
        btn = 8'h04;
        #2;
        reset = 1'b0;
        #1;
        chk("async_pending", pending, 8'h00);
        chk("async_cerut", etaj_cerut, 0);
        chk("async_cv", cerere_valida, 0);
        chk("async_dir", directie, 0);
        cyc(2);
        chk("in_reset_pending", pending, 8'h00);
        reset = 1'b1;
        cyc(1);
        chk("held_through_reset", pending, 8'h04);
        cyc(3);
        chk("held_through_reset_once", pending, 8'h04);
        btn = 8'h00;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
